// File: rtl/vx_alu_pe_router_pkg.sv
// Shared constants for the ALU processing-element router and its arbiter.
package vx_alu_pe_router_pkg;

    localparam int PE_IDX_INT = 0;
    localparam int PE_IDX_MDV = 1;
    localparam int PE_IDX_MAX = 7;

    // Index width for n PEs; a single PE still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vx_alu_pe_router_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or after the pointer wins, else the lowest overall.
module vx_rr_arbiter
    import vx_alu_pe_router_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = sel_width(N)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    output logic [N-1:0]     o_grant,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_idx_hi;
    logic [SEL_W-1:0] w_idx_lo;
    logic             w_hit_hi;
    logic             w_hit_any;

    always_comb begin
        w_hit_hi  = 1'b0;
        w_hit_any = 1'b0;
        w_idx_hi  = '0;
        w_idx_lo  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_hit_any = 1'b1;
                w_idx_lo  = SEL_W'(j);
                if (j >= int'(r_ptr)) begin
                    w_hit_hi = 1'b1;
                    w_idx_hi = SEL_W'(j);
                end
            end
        end
    end

    assign o_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
    assign o_any = w_hit_any;

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < N; j++) begin
            o_grant[j] = w_hit_any && (o_idx == SEL_W'(j));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_en && w_hit_any) begin
            r_ptr <= (o_idx == SEL_W'(N - 1)) ? '0 : o_idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/vx_alu_pe_router.sv
// Steers execute requests to PEs under per-PE credit limits and merges PE responses
// through a round-robin arbiter into one registered output stage.
module vx_alu_pe_router
    import vx_alu_pe_router_pkg::*;
#(
    parameter int PE_COUNT     = 2,
    parameter int REQ_W        = 64,
    parameter int RSP_W        = 64,
    parameter int MAX_INFLIGHT = 4,
    parameter int SEL_W        = sel_width(PE_COUNT),
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_in_valid,
    input  logic [REQ_W-1:0]          i_in_data,
    input  logic [SEL_W-1:0]          i_in_pe_sel,
    output logic                      o_in_ready,
    output logic [PE_COUNT-1:0]       o_pe_req_valid,
    output logic [REQ_W-1:0]          o_pe_req_data,
    input  logic [PE_COUNT-1:0]       i_pe_req_ready,
    input  logic [PE_COUNT-1:0]       i_pe_rsp_valid,
    input  logic [PE_COUNT*RSP_W-1:0] i_pe_rsp_data,
    output logic [PE_COUNT-1:0]       o_pe_rsp_ready,
    output logic                      o_out_valid,
    output logic [RSP_W-1:0]          o_out_data,
    output logic [SEL_W-1:0]          o_out_pe_idx,
    input  logic                      i_out_ready,
    output logic [PE_COUNT*CNT_W-1:0] o_inflight,
    output logic                      o_busy,
    output logic [1:0]                o_err
);

    logic [CNT_W-1:0]    r_cnt [PE_COUNT];
    logic                r_out_valid;
    logic [RSP_W-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_pe_idx;
    logic [1:0]          r_err;

    logic [PE_COUNT-1:0] w_ok;
    logic [PE_COUNT-1:0] w_req_fire;
    logic [PE_COUNT-1:0] w_rsp_fire;
    logic [PE_COUNT-1:0] w_grant;
    logic [SEL_W-1:0]    w_gidx;
    logic                w_any_rsp;
    logic                w_fire;
    logic                w_sel_in_range;
    logic                w_dec_at_zero;
    logic [RSP_W-1:0]    w_rsp_data;

    always_comb begin
        for (int i = 0; i < PE_COUNT; i++) begin
            w_ok[i] = r_cnt[i] < CNT_W'(MAX_INFLIGHT);
        end
    end

    assign w_sel_in_range = int'(i_in_pe_sel) < PE_COUNT;
    assign o_pe_req_data  = i_in_data;

    // Out-of-range selects are accepted and dropped so dispatch never stalls on them.
    always_comb begin
        o_pe_req_valid = '0;
        o_in_ready     = !w_sel_in_range;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (i_in_pe_sel == SEL_W'(i)) begin
                o_pe_req_valid[i] = i_in_valid && w_ok[i];
                o_in_ready        = i_pe_req_ready[i] && w_ok[i];
            end
        end
    end

    assign w_req_fire = o_pe_req_valid & i_pe_req_ready;

    vx_rr_arbiter #(
        .N     (PE_COUNT),
        .SEL_W (SEL_W)
    ) u_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (i_pe_rsp_valid),
        .i_en    (w_fire),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any_rsp)
    );

    assign w_fire         = w_any_rsp && (!r_out_valid || i_out_ready);
    assign o_pe_rsp_ready = w_grant & {PE_COUNT{w_fire}};
    assign w_rsp_fire     = i_pe_rsp_valid & o_pe_rsp_ready;

    always_comb begin
        w_rsp_data    = '0;
        w_dec_at_zero = 1'b0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (w_grant[i]) begin
                w_rsp_data = i_pe_rsp_data[i*RSP_W +: RSP_W];
            end
            if (w_rsp_fire[i] && !w_req_fire[i] && (r_cnt[i] == '0)) begin
                w_dec_at_zero = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < PE_COUNT; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PE_COUNT; i++) begin
                if (w_req_fire[i] && !w_rsp_fire[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (!w_req_fire[i] && w_rsp_fire[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_pe_idx <= '0;
            r_err        <= '0;
        end else begin
            if (w_fire) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_rsp_data;
                r_out_pe_idx <= w_gidx;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (i_in_valid && !w_sel_in_range) begin
                r_err[0] <= 1'b1;
            end
            if (w_dec_at_zero) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_busy = r_out_valid;
        for (int i = 0; i < PE_COUNT; i++) begin
            o_inflight[i*CNT_W +: CNT_W] = r_cnt[i];
            if (r_cnt[i] != '0) begin
                o_busy = 1'b1;
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_pe_idx = r_out_pe_idx;
    assign o_err        = r_err;

endmodule

// File: tb/tb_vx_alu_pe_router.sv
// Directed bench for vx_alu_pe_router with three PEs and two credits per PE.
module tb_vx_alu_pe_router;

    localparam int PE_COUNT     = 3;
    localparam int REQ_W        = 16;
    localparam int RSP_W        = 16;
    localparam int MAX_INFLIGHT = 2;
    localparam int SEL_W        = 2;
    localparam int CNT_W        = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      in_valid;
    logic [REQ_W-1:0]          in_data;
    logic [SEL_W-1:0]          in_pe_sel;
    logic                      in_ready;
    logic [PE_COUNT-1:0]       pe_req_valid;
    logic [REQ_W-1:0]          pe_req_data;
    logic [PE_COUNT-1:0]       pe_req_ready;
    logic [PE_COUNT-1:0]       pe_rsp_valid;
    logic [PE_COUNT*RSP_W-1:0] pe_rsp_data;
    logic [PE_COUNT-1:0]       pe_rsp_ready;
    logic                      out_valid;
    logic [RSP_W-1:0]          out_data;
    logic [SEL_W-1:0]          out_pe_idx;
    logic                      out_ready;
    logic [PE_COUNT*CNT_W-1:0] inflight;
    logic                      busy;
    logic [1:0]                err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_alu_pe_router #(
        .PE_COUNT     (PE_COUNT),
        .REQ_W        (REQ_W),
        .RSP_W        (RSP_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_in_valid     (in_valid),
        .i_in_data      (in_data),
        .i_in_pe_sel    (in_pe_sel),
        .o_in_ready     (in_ready),
        .o_pe_req_valid (pe_req_valid),
        .o_pe_req_data  (pe_req_data),
        .i_pe_req_ready (pe_req_ready),
        .i_pe_rsp_valid (pe_rsp_valid),
        .i_pe_rsp_data  (pe_rsp_data),
        .o_pe_rsp_ready (pe_rsp_ready),
        .o_out_valid    (out_valid),
        .o_out_data     (out_data),
        .o_out_pe_idx   (out_pe_idx),
        .i_out_ready    (out_ready),
        .o_inflight     (inflight),
        .o_busy         (busy),
        .o_err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_pe_sel    = '0;
        pe_req_ready = '1;
        pe_rsp_valid = '0;
        pe_rsp_data  = {16'h00C2, 16'h00B1, 16'h00A0};
        out_ready    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    task automatic send_one(input logic [SEL_W-1:0] sel);
        in_valid  = 1'b1;
        in_pe_sel = sel;
        tick();
        in_valid = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_vec++;
        if (inflight !== 6'd0) begin n_err++; $display("FAIL reset_inflight got %h want 0", inflight); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_vec++;
        if (err !== 2'b00) begin n_err++; $display("FAIL reset_err got %b want 00", err); end
    endtask

    task automatic test_credit();
        do_reset();
        in_valid  = 1'b1;
        in_pe_sel = 2'd1;
        in_data   = 16'h1234;
        settle();
        n_vec++;
        if (pe_req_valid !== 3'b010 || in_ready !== 1'b1 || pe_req_data !== 16'h1234) begin
            n_err++; $display("FAIL credit_first got valid=%b ready=%b data=%h want 010/1/1234", pe_req_valid, in_ready, pe_req_data);
        end
        tick();
        tick();
        settle();
        n_vec++;
        if (inflight[3:2] !== 2'd2) begin n_err++; $display("FAIL credit_count2 got %0d want 2", inflight[3:2]); end
        n_vec++;
        if (in_ready !== 1'b0 || pe_req_valid !== 3'b000) begin
            n_err++; $display("FAIL credit_block got ready=%b valid=%b want 0/000", in_ready, pe_req_valid);
        end
        pe_rsp_valid = 3'b010;
        settle();
        n_vec++;
        if (pe_rsp_ready !== 3'b010) begin n_err++; $display("FAIL credit_rsp_ready got %b want 010", pe_rsp_ready); end
        tick();
        pe_rsp_valid = 3'b000;
        settle();
        n_vec++;
        if (inflight[3:2] !== 2'd1 || in_ready !== 1'b1 || pe_req_valid !== 3'b010) begin
            n_err++; $display("FAIL credit_release got cnt=%0d ready=%b valid=%b want 1/1/010", inflight[3:2], in_ready, pe_req_valid);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h00B1 || out_pe_idx !== 2'd1) begin
            n_err++; $display("FAIL credit_out got v=%b d=%h i=%0d want 1/00b1/1", out_valid, out_data, out_pe_idx);
        end
        tick();
        in_valid = 1'b0;
        settle();
        n_vec++;
        if (inflight[3:2] !== 2'd2 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL credit_third got cnt=%0d ov=%b busy=%b want 2/0/1", inflight[3:2], out_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [RSP_W-1:0] exp_d [3];
        exp_d[0] = 16'h00A0;
        exp_d[1] = 16'h00B1;
        exp_d[2] = 16'h00C2;
        do_reset();
        send_one(2'd0);
        send_one(2'd1);
        send_one(2'd2);
        pe_rsp_valid = 3'b111;
        settle();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (pe_rsp_ready !== 3'(1 << k)) begin
                n_err++; $display("FAIL rr_grant%0d got %b want %b", k, pe_rsp_ready, 3'(1 << k));
            end
            tick();
            pe_rsp_valid[k] = 1'b0;
            settle();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_pe_idx !== 2'(k)) begin
                n_err++; $display("FAIL rr_out%0d got v=%b d=%h i=%0d want 1/%h/%0d", k, out_valid, out_data, out_pe_idx, exp_d[k], k);
            end
        end
        tick();
        settle();
        n_vec++;
        if (out_valid !== 1'b0 || inflight !== 6'd0) begin
            n_err++; $display("FAIL rr_drain got v=%b inflight=%h want 0/0", out_valid, inflight);
        end
        pe_rsp_valid = 3'b011;
        settle();
        n_vec++;
        if (pe_rsp_ready !== 3'b001) begin n_err++; $display("FAIL rr_ptr_wrap got %b want 001", pe_rsp_ready); end
        pe_rsp_valid = 3'b000;
        settle();
    endtask

    task automatic test_stall();
        do_reset();
        send_one(2'd1);
        send_one(2'd2);
        pe_rsp_valid = 3'b110;
        tick();
        pe_rsp_valid = 3'b100;
        out_ready    = 1'b0;
        settle();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 16'h00B1 || out_pe_idx !== 2'd1 || pe_rsp_ready !== 3'b000) begin
                n_err++; $display("FAIL stall_hold%0d got v=%b d=%h i=%0d rdy=%b want 1/00b1/1/000", k, out_valid, out_data, out_pe_idx, pe_rsp_ready);
            end
            tick();
            settle();
        end
        out_ready = 1'b1;
        settle();
        n_vec++;
        if (pe_rsp_ready !== 3'b100) begin n_err++; $display("FAIL stall_release got %b want 100", pe_rsp_ready); end
        tick();
        pe_rsp_valid = 3'b000;
        settle();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h00C2 || out_pe_idx !== 2'd2 || inflight !== 6'd0) begin
            n_err++; $display("FAIL stall_pending got v=%b d=%h i=%0d inf=%h want 1/00c2/2/0", out_valid, out_data, out_pe_idx, inflight);
        end
    endtask

    task automatic test_bad_sel();
        do_reset();
        pe_req_ready = 3'b000;
        in_valid     = 1'b1;
        in_pe_sel    = 2'd3;
        settle();
        n_vec++;
        if (in_ready !== 1'b1 || pe_req_valid !== 3'b000) begin
            n_err++; $display("FAIL badsel_accept got ready=%b valid=%b want 1/000", in_ready, pe_req_valid);
        end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        settle();
        n_vec++;
        if (err !== 2'b01 || inflight !== 6'd0) begin
            n_err++; $display("FAIL badsel_sticky got err=%b inf=%h want 01/0", err, inflight);
        end
        do_reset();
        n_vec++;
        if (err !== 2'b00) begin n_err++; $display("FAIL badsel_clear got %b want 00", err); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send_one(2'd0);
        in_valid     = 1'b1;
        in_pe_sel    = 2'd0;
        pe_rsp_valid = 3'b001;
        settle();
        n_vec++;
        if (in_ready !== 1'b1 || pe_rsp_ready !== 3'b001) begin
            n_err++; $display("FAIL simul_setup got ready=%b rsp_rdy=%b want 1/001", in_ready, pe_rsp_ready);
        end
        tick();
        in_valid     = 1'b0;
        pe_rsp_valid = 3'b000;
        settle();
        n_vec++;
        if (inflight[1:0] !== 2'd1) begin n_err++; $display("FAIL simul_count got %0d want 1", inflight[1:0]); end
        pe_rsp_valid = 3'b100;
        tick();
        pe_rsp_valid = 3'b000;
        settle();
        n_vec++;
        if (err !== 2'b10 || inflight[5:4] !== 2'd0 || inflight[1:0] !== 2'd1) begin
            n_err++; $display("FAIL spurious_rsp got err=%b cnt2=%0d cnt0=%0d want 10/0/1", err, inflight[5:4], inflight[1:0]);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h00C2 || out_pe_idx !== 2'd2) begin
            n_err++; $display("FAIL spurious_out got v=%b d=%h i=%0d want 1/00c2/2", out_valid, out_data, out_pe_idx);
        end
    endtask

    initial begin
        test_reset();
        test_credit();
        test_round_robin();
        test_stall();
        test_bad_sel();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
